// File: rtl/victim_buffer_pkg.sv
// Shared types and constants for the write-back victim buffer.
// The optional lookup_data forwarding path is enabled by defining VB_FORWARD_EN.
package victim_buffer_pkg;

    // Byte offset bits within a 16-byte cache line.
    localparam int LINE_OFFSET_BITS = 4;

    typedef logic [127:0] lc3b_c_line;
    typedef logic [11:0]  lc3b_c_tag;

    typedef enum logic {
        VB_IDLE  = 1'b0,
        VB_WRITE = 1'b1
    } vb_state_t;

endpackage

// File: rtl/victim_buffer_fifo_store.sv
// Line storage for the victim buffer: DEPTH x {valid, tag, data} FIFO with
// head/tail pointers, an occupancy count and a parallel tag match in which the
// youngest matching entry wins. The hit data mux exists only with VB_FORWARD_EN.
module victim_fifo_store
    import victim_buffer_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 128,
    parameter int TAG_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [TAG_W-1:0]          i_push_tag,
    input  logic [LINE_W-1:0]         i_push_data,
    input  logic                      i_pop,
    input  logic [TAG_W-1:0]          i_lookup_tag,
    output logic [TAG_W-1:0]          o_head_tag,
    output logic [LINE_W-1:0]         o_head_data,
    output logic                      o_hit,
`ifdef VB_FORWARD_EN
    output logic [LINE_W-1:0]         o_hit_data,
`endif
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_idx;

    // Pointer, valid-bit and count bookkeeping; push and pop never target the
    // same slot because a pop needs count>0 and a push needs count<DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Line payload capture at the tail slot; payload is not reset, validity is.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_tag[r_tail]  <= i_push_tag;
            r_data[r_tail] <= i_push_data;
        end
    end

    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        o_hit = 1'b0;
        w_idx = '0;
`ifdef VB_FORWARD_EN
        o_hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (r_valid[w_idx] && (r_tag[w_idx] == i_lookup_tag)) begin
                o_hit = 1'b1;
`ifdef VB_FORWARD_EN
                o_hit_data = r_data[w_idx];
`endif
            end
        end
    end

    assign o_head_tag  = r_tag[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/victim_buffer.sv
// Write-back victim buffer top: accepts evicted dirty lines from the cache and
// drains them to physical memory one at a time through a two-state FSM that
// inserts one idle cycle after every completed write.
// Define VB_FORWARD_EN to add the lookup_data forwarding port.
module victim_buffer
    import victim_buffer_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              evict_valid,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic              evict_ready,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
`ifdef VB_FORWARD_EN
    output logic [LINE_W-1:0] lookup_data,
`endif
    output logic              empty
);

    localparam int TAG_W = ADDR_W - LINE_OFFSET_BITS;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    vb_state_t          r_state;
    logic               r_pmem_write;
    logic [CNT_W-1:0]   w_count;
    logic [TAG_W-1:0]   w_head_tag;
    logic [LINE_W-1:0]  w_head_data;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_bits;

    // Ready comes only from the registered count, never from pmem_resp, so a
    // full buffer refuses a push even in the cycle that pops its head.
    assign evict_ready = (w_count != CNT_W'(DEPTH));
    assign w_push      = evict_valid && evict_ready;
    assign w_pop       = (r_state == VB_WRITE) && pmem_resp;

    // Byte offset bits of the incoming addresses carry no line information.
    assign w_unused_bits = ^{evict_addr[LINE_OFFSET_BITS-1:0],
                             lookup_addr[LINE_OFFSET_BITS-1:0]};

    victim_fifo_store #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_tag   (evict_addr[ADDR_W-1:LINE_OFFSET_BITS]),
        .i_push_data  (evict_data),
        .i_pop        (w_pop),
        .i_lookup_tag (lookup_addr[ADDR_W-1:LINE_OFFSET_BITS]),
        .o_head_tag   (w_head_tag),
        .o_head_data  (w_head_data),
        .o_hit        (lookup_hit),
`ifdef VB_FORWARD_EN
        .o_hit_data   (lookup_data),
`endif
        .o_count      (w_count)
    );

    // Drain FSM: leave IDLE whenever lines are queued, hold WRITE until memory
    // acknowledges, then return to IDLE for one cycle before the next line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= VB_IDLE;
            r_pmem_write <= 1'b0;
        end else begin
            case (r_state)
                VB_IDLE: begin
                    if (w_count != '0) begin
                        r_state      <= VB_WRITE;
                        r_pmem_write <= 1'b1;
                    end
                end
                VB_WRITE: begin
                    if (pmem_resp) begin
                        r_state      <= VB_IDLE;
                        r_pmem_write <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pmem_write   = r_pmem_write;
    assign pmem_address = {w_head_tag, {LINE_OFFSET_BITS{1'b0}}};
    assign pmem_wdata   = w_head_data;
    assign empty        = (w_count == '0);

endmodule
